// File: rtl/rr_mux_pkg.sv
// Shared definitions for the rr_mux arbitrated multiplexer family.
package rr_mux_pkg;

    typedef enum logic {
        FIXED       = 1'b0,
        ROUND_ROBIN = 1'b1
    } rr_mode_e;

    // Ceiling log2 used to size channel indices.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Producer-side and consumer-side handshake bundle of rr_mux.
interface rr_mux_if
    import rr_mux_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 32,
    parameter int SEL_W = clog2(N)
) ();

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_mux_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] cand_s;

    // Scan ptr..N-1,0..ptr-1; the sum is reduced modulo N so a non power-of-two N never indexes past N-1.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < N; i++) begin
            sum_s   = {1'b0, ptr} + (SEL_W+1)'(i);
            cand_s  = (sum_s >= (SEL_W+1)'(N)) ? SEL_W'(sum_s - (SEL_W+1)'(N)) : sum_s[SEL_W-1:0];
            gnt_idx = (req[cand_s] & ~any) ? cand_s : gnt_idx;
            any     = any | req[cand_s];
        end
    end

    // One-hot form of the winning index, all-zero when nobody requests.
    always_comb begin
        gnt_onehot          = '0;
        gnt_onehot[gnt_idx] = any;
    end

endmodule

// File: rtl/rr_mux_chk.sv
// Protocol checker for rr_mux: producer stability and legal output index.
module rr_mux_chk #(
    parameter int N     = 2,
    parameter int W     = 32,
    parameter int SEL_W = 1
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N-1:0]     in_valid,
    input logic [N-1:0]     in_ready,
    input logic [N*W-1:0]   in_data,
    input logic             out_valid,
    input logic [SEL_W-1:0] out_sel
);

    for (genvar i = 0; i < N; i++) begin : gChan
        a_hold : assert property (@(posedge clk) disable iff (!rst_n)
            (in_valid[i] && !in_ready[i]) |=> (in_valid[i] && $stable(in_data[i*W +: W])));
    end

    a_selRange : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (int'(out_sel) < N));

    a_readyOneHot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

endmodule

// File: rtl/rr_mux.sv
// N-channel registered multiplexer with valid/ready handshakes and round-robin or fixed-priority arbitration.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 32,
    parameter int RR    = 1,
    parameter int SEL_W = clog2(N)
) (
    input logic    clk,
    input logic    rst_n,
    rr_mux_if.slave bus
);

    logic             load_s;
    logic             any_s;
    logic             accept_s;
    logic [N-1:0]     gntOneHot_s;
    logic [SEL_W-1:0] gntIdx_s;
    logic [SEL_W-1:0] arbPtr_s;
    logic             outValid_r;
    logic [W-1:0]     outData_r;
    logic [SEL_W-1:0] outSel_r;

    assign load_s   = ~outValid_r | bus.out_ready;
    assign accept_s = load_s & any_s;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (bus.in_valid),
        .ptr        (arbPtr_s),
        .gnt_onehot (gntOneHot_s),
        .gnt_idx    (gntIdx_s),
        .any        (any_s)
    );

    // Grant is withheld while reset is asserted so nothing looks accepted during reset.
    assign bus.in_ready = gntOneHot_s & {N{accept_s & rst_n}};

    if (RR == int'(ROUND_ROBIN)) begin : gPtr
        logic [SEL_W-1:0] ptr_r;
        logic [SEL_W-1:0] ptrNext_s;

        assign ptrNext_s = (gntIdx_s == SEL_W'(N-1)) ? SEL_W'(0) : gntIdx_s + SEL_W'(1);
        assign arbPtr_s  = ptr_r;

        // Rotate priority past the last winner, only on an accepted beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_r <= SEL_W'(0);
            end else if (accept_s) begin
                ptr_r <= ptrNext_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end else begin : gNoPtr
        assign arbPtr_s = SEL_W'(0);
    end

    // Single-entry output register: load on accept, empty on drain-only, hold when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_r <= 1'b0;
            outData_r  <= W'(0);
            outSel_r   <= SEL_W'(0);
        end else if (accept_s) begin
            outValid_r <= 1'b1;
            outData_r  <= bus.in_data[gntIdx_s*W +: W];
            outSel_r   <= gntIdx_s;
        end else if (bus.out_ready) begin
            outValid_r <= 1'b0;
        end else begin
            outValid_r <= outValid_r;
        end
    end

    assign bus.out_valid = outValid_r;
    assign bus.out_data  = outData_r;
    assign bus.out_sel   = outSel_r;

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: table-driven vectors plus a per-DUT beat scoreboard.
module tb_rr_mux;

    typedef struct {
        int       d;
        logic [3:0] v;
        logic       r;
        logic [3:0] er;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    logic clk;
    logic rst_n;
    logic [3:0] vld [3];
    logic       ordy [3];
    logic [3:0] irdy [3];
    logic       oval [3];
    logic [7:0] odat [3];
    logic [1:0] osel [3];
    logic [31:0] dat4;
    logic [23:0] dat3;

    int checks;
    int errors;
    logic  mval [3];
    beat_t sbq [3][$];
    vec_t  tbl [$];

    rr_mux_if #(.N(4), .W(8)) busRr ();
    rr_mux_if #(.N(4), .W(8)) busFp ();
    rr_mux_if #(.N(3), .W(8)) bus3 ();

    rr_mux #(.N(4), .W(8), .RR(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(busRr));
    rr_mux #(.N(4), .W(8), .RR(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(busFp));
    rr_mux #(.N(3), .W(8), .RR(1)) u_r3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    rr_mux_chk #(.N(4), .W(8), .SEL_W(2)) c_rr (.clk(clk), .rst_n(rst_n), .in_valid(busRr.in_valid),
        .in_ready(busRr.in_ready), .in_data(busRr.in_data), .out_valid(busRr.out_valid), .out_sel(busRr.out_sel));
    rr_mux_chk #(.N(4), .W(8), .SEL_W(2)) c_fp (.clk(clk), .rst_n(rst_n), .in_valid(busFp.in_valid),
        .in_ready(busFp.in_ready), .in_data(busFp.in_data), .out_valid(busFp.out_valid), .out_sel(busFp.out_sel));
    rr_mux_chk #(.N(3), .W(8), .SEL_W(2)) c_r3 (.clk(clk), .rst_n(rst_n), .in_valid(bus3.in_valid),
        .in_ready(bus3.in_ready), .in_data(bus3.in_data), .out_valid(bus3.out_valid), .out_sel(bus3.out_sel));

    assign dat4 = {8'h33, 8'hA5, 8'h22, 8'h11};
    assign dat3 = {8'hC3, 8'hB2, 8'hA1};

    assign busRr.in_valid  = vld[0];
    assign busRr.in_data   = dat4;
    assign busRr.out_ready = ordy[0];
    assign busFp.in_valid  = vld[1];
    assign busFp.in_data   = dat4;
    assign busFp.out_ready = ordy[1];
    assign bus3.in_valid   = vld[2][2:0];
    assign bus3.in_data    = dat3;
    assign bus3.out_ready  = ordy[2];

    assign irdy[0] = busRr.in_ready;
    assign irdy[1] = busFp.in_ready;
    assign irdy[2] = {1'b0, bus3.in_ready};
    assign oval[0] = busRr.out_valid;
    assign oval[1] = busFp.out_valid;
    assign oval[2] = bus3.out_valid;
    assign odat[0] = busRr.out_data;
    assign odat[1] = busFp.out_data;
    assign odat[2] = bus3.out_data;
    assign osel[0] = busRr.out_sel;
    assign osel[1] = busFp.out_sel;
    assign osel[2] = bus3.out_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ohIdx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] chanData(input int d, input logic [1:0] idx);
        logic [31:0] t;
        t = (d == 2) ? {8'h00, dat3} : dat4;
        return t[idx*8 +: 8];
    endfunction

    function automatic void addRow(input int d, input logic [3:0] v, input logic r, input logic [3:0] er);
        vec_t x;
        x.d = d; x.v = v; x.r = r; x.er = er;
        tbl.push_back(x);
    endfunction

    // Entered just after a rising edge; drives one cycle of stimulus and checks the result.
    task automatic runRow(input int d, input logic [3:0] v, input logic r, input logic [3:0] er);
        beat_t b;
        vld[d]  = v;
        ordy[d] = r;
        #1;
        chk($sformatf("in_ready[d%0d]", d), {28'd0, irdy[d]}, {28'd0, er});
        if (mval[d]) begin
            if (sbq[d].size() == 0) begin
                chk($sformatf("sb_empty[d%0d]", d), 32'd0, 32'd1);
            end else begin
                b = sbq[d][0];
                chk($sformatf("out_data[d%0d]", d), {24'd0, odat[d]}, {24'd0, b.data});
                chk($sformatf("out_sel[d%0d]", d), {30'd0, osel[d]}, {30'd0, b.sel});
                if (r) void'(sbq[d].pop_front());
            end
        end
        if (er != 4'd0) begin
            b.sel  = ohIdx(er);
            b.data = chanData(d, b.sel);
            sbq[d].push_back(b);
        end
        mval[d] = (er != 4'd0) | (mval[d] & ~r);
        @(posedge clk);
        #1;
        chk($sformatf("out_valid[d%0d]", d), {31'd0, oval[d]}, {31'd0, mval[d]});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 3; i++) begin
            vld[i]  = 4'd0;
            ordy[i] = 1'b1;
            mval[i] = 1'b0;
        end

        // Round-robin, N=4: fairness, then channel 2 (0xA5) stalled for three cycles.
        addRow(0, 4'b1111, 1'b1, 4'b0001);
        addRow(0, 4'b1111, 1'b1, 4'b0010);
        addRow(0, 4'b1111, 1'b1, 4'b0100);
        addRow(0, 4'b1111, 1'b1, 4'b1000);
        addRow(0, 4'b1111, 1'b1, 4'b0001);
        addRow(0, 4'b1111, 1'b1, 4'b0010);
        addRow(0, 4'b1111, 1'b1, 4'b0100);
        addRow(0, 4'b1111, 1'b0, 4'b0000);
        addRow(0, 4'b1111, 1'b0, 4'b0000);
        addRow(0, 4'b1111, 1'b0, 4'b0000);
        addRow(0, 4'b1111, 1'b1, 4'b1000);
        addRow(0, 4'b1111, 1'b1, 4'b0001);
        addRow(0, 4'b1110, 1'b1, 4'b0010);
        addRow(0, 4'b1100, 1'b1, 4'b0100);
        addRow(0, 4'b1000, 1'b1, 4'b1000);
        addRow(0, 4'b0000, 1'b1, 4'b0000);
        // Fixed priority, N=4: lowest index always wins.
        addRow(1, 4'b1111, 1'b1, 4'b0001);
        addRow(1, 4'b1111, 1'b1, 4'b0001);
        addRow(1, 4'b1111, 1'b1, 4'b0001);
        addRow(1, 4'b1110, 1'b1, 4'b0010);
        addRow(1, 4'b1110, 1'b1, 4'b0010);
        addRow(1, 4'b1100, 1'b1, 4'b0100);
        addRow(1, 4'b1100, 1'b0, 4'b0000);
        addRow(1, 4'b1100, 1'b1, 4'b0100);
        addRow(1, 4'b1000, 1'b1, 4'b1000);
        addRow(1, 4'b0000, 1'b1, 4'b0000);
        // Round-robin, N=3: sparse request at ptr=2, then wrap 2 -> 0.
        addRow(2, 4'b0001, 1'b1, 4'b0001);
        addRow(2, 4'b0010, 1'b1, 4'b0010);
        addRow(2, 4'b0010, 1'b1, 4'b0010);
        addRow(2, 4'b0111, 1'b1, 4'b0100);
        addRow(2, 4'b0011, 1'b1, 4'b0001);
        addRow(2, 4'b0010, 1'b1, 4'b0010);
        addRow(2, 4'b0000, 1'b1, 4'b0000);

        // Reset with requests pending: nothing granted, outputs cleared.
        rst_n  = 1'b0;
        vld[0] = 4'b0011;
        #8;
        chk("rst_out_valid", {31'd0, oval[0]}, 32'd0);
        chk("rst_out_sel", {30'd0, osel[0]}, 32'd0);
        chk("rst_in_ready", {28'd0, irdy[0]}, 32'd0);
        chk("rst_in_ready_n3", {28'd0, irdy[2]}, 32'd0);
        vld[0] = 4'b0000;
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            runRow(tbl[k].d, tbl[k].v, tbl[k].r, tbl[k].er);
        end

        // Asynchronous reset while a beat is stalled: beat lost, pointer back to 0.
        runRow(0, 4'b0001, 1'b0, 4'b0001);
        runRow(0, 4'b0000, 1'b0, 4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, oval[0]}, 32'd0);
        chk("async_rst_in_ready", {28'd0, irdy[0]}, 32'd0);
        sbq[0].delete();
        mval[0] = 1'b0;
        #1;
        rst_n = 1'b1;
        runRow(0, 4'b0000, 1'b1, 4'b0000);
        runRow(0, 4'b0011, 1'b1, 4'b0001);
        runRow(0, 4'b0010, 1'b1, 4'b0010);
        runRow(0, 4'b0000, 1'b1, 4'b0000);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_drained[d%0d]", i), 32'(sbq[i].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
